// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM.
// One state per clock; memory states stall on mem_ready.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PcWrite,
  output logic       PcWriteCond,
  output logic [1:0] PcSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_IDLE   = 4'd15
  } state_t;

  state_t     cur;
  state_t     nxt;
  logic [5:0] op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= S_IDLE;
      op_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE)
        op_q <= op;
    end
  end

  assign state = cur;

  always_comb begin
    nxt         = S_FETCH;
    PcWrite     = 1'b0;
    PcWriteCond = 1'b0;
    PcSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PcWrite = mem_ready;
        nxt     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW,
          OP_SW:   nxt = S_MEMADR;
          OP_R:    nxt = S_EXEC;
          OP_BEQ:  nxt = S_BRANCH;
          OP_J:    nxt = S_JUMP;
          OP_ADDI: nxt = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        nxt      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PcWriteCond = 1'b1;
        PcSource    = 2'b01;
      end
      S_JUMP: begin
        PcWrite  = 1'b1;
        PcSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl.
// Stimulus queues expected control words; monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] PcSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .PcSource(PcSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {state, PcWrite, PcWriteCond, PcSource, IorD, MemRead, MemWrite,
  //  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal}
  localparam logic [20:0] E_IDLE = {4'd15, 4'b0000, 4'b0000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_F1   = {4'd0,  4'b1000, 4'b0101, 3'b000, 1'b0, 2'b01, 2'b00, 1'b0};
  localparam logic [20:0] E_F0   = {4'd0,  4'b0000, 4'b0100, 3'b000, 1'b0, 2'b01, 2'b00, 1'b0};
  localparam logic [20:0] E_DEC  = {4'd1,  4'b0000, 4'b0000, 3'b000, 1'b0, 2'b11, 2'b00, 1'b0};
  localparam logic [20:0] E_DECI = {4'd1,  4'b0000, 4'b0000, 3'b000, 1'b0, 2'b11, 2'b00, 1'b1};
  localparam logic [20:0] E_MADR = {4'd2,  4'b0000, 4'b0000, 3'b000, 1'b1, 2'b10, 2'b00, 1'b0};
  localparam logic [20:0] E_MRD  = {4'd3,  4'b0000, 4'b1100, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_MWB  = {4'd4,  4'b0000, 4'b0000, 3'b101, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_MWR  = {4'd5,  4'b0000, 4'b1010, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_EXEC = {4'd6,  4'b0000, 4'b0000, 3'b000, 1'b1, 2'b00, 2'b10, 1'b0};
  localparam logic [20:0] E_AWB  = {4'd7,  4'b0000, 4'b0000, 3'b011, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_BR   = {4'd8,  4'b0101, 4'b0000, 3'b000, 1'b1, 2'b00, 2'b01, 1'b0};
  localparam logic [20:0] E_JMP  = {4'd9,  4'b1010, 4'b0000, 3'b000, 1'b0, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] E_AIEX = {4'd10, 4'b0000, 4'b0000, 3'b000, 1'b1, 2'b10, 2'b00, 1'b0};
  localparam logic [20:0] E_AIWB = {4'd11, 4'b0000, 4'b0000, 3'b001, 1'b0, 2'b00, 2'b00, 1'b0};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, RTY = 6'b000000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic [20:0] v;
    string       n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event probe;

  logic [20:0] act;
  assign act = {state, PcWrite, PcWriteCond, PcSource, IorD, MemRead,
                MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, illegal_op};

  always begin
    @(negedge clk or probe);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h want %h (state %0d)", e.n, act, e.v, state);
      end
    end
  end

  task automatic cyc(input logic [5:0] o, input logic mr,
                     input logic [20:0] e, input string n);
    @(posedge clk);
    #1;
    op        = o;
    mem_ready = mr;
    q.push_back('{e, n});
  endtask

  task automatic chk_now(input logic [20:0] e, input string n);
    q.push_back('{e, n});
    -> probe;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    op        = RTY;
    mem_ready = 1'b1;
    #2;
    q.push_back('{E_IDLE, "rst_hold"});
    @(negedge clk);
    #1;
    reset = 1'b1;
    chk_now(E_IDLE, "rst_release");
    cyc(RTY, 1'b1, E_F1, "fetch_first");
    cyc(LW, 1'b1, E_DEC, "lw_decode");
    cyc(SW, 1'b1, E_MADR, "lw_memadr");
    cyc(SW, 1'b1, E_MRD, "lw_memrd_latch");
    cyc(RTY, 1'b1, E_MWB, "lw_memwb");
    cyc(RTY, 1'b1, E_F1, "lw_done");
    cyc(SW, 1'b1, E_DEC, "sw_decode");
    cyc(RTY, 1'b1, E_MADR, "sw_memadr");
    cyc(RTY, 1'b0, E_MWR, "sw_stall1");
    cyc(RTY, 1'b0, E_MWR, "sw_stall2");
    cyc(RTY, 1'b1, E_MWR, "sw_write");
    cyc(RTY, 1'b0, E_F0, "fetch_stall");
    cyc(RTY, 1'b1, E_F1, "fetch_go");
    cyc(BEQ, 1'b1, E_DEC, "beq_decode");
    cyc(RTY, 1'b1, E_BR, "beq_branch");
    cyc(RTY, 1'b1, E_F1, "beq_done");
    cyc(JMP, 1'b1, E_DEC, "j_decode");
    cyc(RTY, 1'b1, E_JMP, "j_jump");
    cyc(RTY, 1'b1, E_F1, "j_done");
    cyc(ADDI, 1'b1, E_DEC, "addi_decode");
    cyc(RTY, 1'b1, E_AIEX, "addi_ex");
    cyc(RTY, 1'b1, E_AIWB, "addi_wb");
    cyc(RTY, 1'b1, E_F1, "addi_done");
    cyc(BAD, 1'b1, E_DECI, "illegal_decode");
    cyc(RTY, 1'b1, E_F1, "illegal_next");
    cyc(LW, 1'b1, E_DEC, "lw2_decode");
    cyc(RTY, 1'b1, E_MADR, "lw2_memadr");
    cyc(RTY, 1'b0, E_MRD, "lw2_rd_stall");
    cyc(RTY, 1'b1, E_MRD, "lw2_rd");
    cyc(RTY, 1'b1, E_MWB, "lw2_wb");
    cyc(RTY, 1'b1, E_F1, "lw2_done");
    cyc(RTY, 1'b1, E_DEC, "r_decode");
    cyc(RTY, 1'b1, E_EXEC, "r_exec");
    cyc(RTY, 1'b1, E_AWB, "r_aluwb");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_now(E_IDLE, "abort_async");
    cyc(RTY, 1'b1, E_IDLE, "abort_hold");
    @(negedge clk);
    #1;
    reset = 1'b1;
    cyc(RTY, 1'b1, E_F1, "refetch");
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
